// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   ALUOP_*      opcode encodings presented on aluop_i
//   alu_state_e  control FSM states of alu_iter
package alu_pkg;

    localparam int unsigned ALUOP_AND   = 0;
    localparam int unsigned ALUOP_OR    = 1;
    localparam int unsigned ALUOP_NOR   = 2;
    localparam int unsigned ALUOP_LUI   = 3;
    localparam int unsigned ALUOP_ADD   = 4;
    localparam int unsigned ALUOP_SUB   = 5;
    localparam int unsigned ALUOP_SLT   = 6;
    localparam int unsigned ALUOP_SLTU  = 7;
    localparam int unsigned ALUOP_MULT  = 8;
    localparam int unsigned ALUOP_MULTU = 9;
    localparam int unsigned ALUOP_DIV   = 10;
    localparam int unsigned ALUOP_DIVU  = 11;
    localparam int unsigned ALUOP_SLL   = 12;
    localparam int unsigned ALUOP_SRL   = 13;
    localparam int unsigned ALUOP_SRA   = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_iter_mdu.sv
// alu_iter_mdu: 1 bit/cycle multiply (shift-add) / divide (restoring) datapath.
// Optional feature macro: ALU_DIV_EN (divider datapath present only when defined).
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset (aborts iteration)
//   start_i          load operands; performs the first iteration on the same edge
//   div_i            1 = divide, 0 = multiply
//   signed_i         operands are two's complement
//   a_i, b_i         multiplicand/multiplier or dividend/divisor
//   busy_o           iteration in progress
//   last_o           the current cycle's edge performs the final iteration
//   result_o         {hi,lo} with sign correction applied; valid once busy_o drops
module alu_iter_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               div_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               last_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q, lo_q, mc_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, neg_prod_q;
    logic [WIDTH-1:0] a_mag, b_mag, cur_hi, cur_lo, cur_mc, step_hi, step_lo;
    logic [WIDTH:0]   mul_sum;
    logic             div_sel;

`ifdef ALU_DIV_EN
    logic             div_q, div0_q, neg_rem_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [WIDTH:0]   div_shift;
    logic             div_ok;

    assign div_sel = start_i ? div_i : div_q;
`else
    logic div_unused;
    assign div_unused = div_i;
    assign div_sel    = 1'b0;
`endif

    assign a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // First iteration runs straight off the freshly loaded operands so that
    // WIDTH iterations finish one cycle earlier than a separate load cycle would.
    always_comb begin
        if (start_i) begin
            cur_hi = '0;
            cur_lo = div_sel ? a_mag : b_mag;
            cur_mc = div_sel ? b_mag : a_mag;
        end else begin
            cur_hi = hi_q;
            cur_lo = lo_q;
            cur_mc = mc_q;
        end
    end

    always_comb begin
        mul_sum = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_mc} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_shift = {cur_hi, cur_lo[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, cur_mc};
        if (div_sel) begin
            step_hi = div_ok ? WIDTH'(div_shift - {1'b0, cur_mc}) : div_shift[WIDTH-1:0];
            step_lo = {cur_lo[WIDTH-2:0], div_ok};
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mc_q       <= '0;
            neg_prod_q <= 1'b0;
        end else if (start_i || busy_q) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            mc_q  <= cur_mc;
            cnt_q <= start_i ? CW'(1) : cnt_q + CW'(1);
            if (start_i) begin
                busy_q     <= 1'b1;
                neg_prod_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            end else if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end

`ifdef ALU_DIV_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q     <= 1'b0;
            div0_q    <= 1'b0;
            neg_rem_q <= 1'b0;
            a_raw_q   <= '0;
        end else if (start_i) begin
            div_q     <= div_i;
            div0_q    <= div_i && (b_i == '0);
            neg_rem_q <= signed_i && a_i[WIDTH-1];
            a_raw_q   <= a_i;
        end
    end
`endif

    assign busy_o = busy_q;
    assign last_o = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        result_o = neg_prod_q ? -{hi_q, lo_q} : {hi_q, lo_q};
`ifdef ALU_DIV_EN
        if (div_q) begin
            if (div0_q) result_o = {a_raw_q, {WIDTH{1'b1}}};
            else        result_o = {neg_rem_q ? -hi_q : hi_q, neg_prod_q ? -lo_q : lo_q};
        end
`endif
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with valid/ready handshake on both sides.
// Optional feature macro: ALU_DIV_EN (DIV/DIVU implemented; otherwise undefined opcodes).
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   valid_i / ready_o         request handshake; operands taken on valid_i && ready_o
//   aluop_i, src0_i, src1_i   opcode (alu_pkg ALUOP_*), operands (src0_i = shamt for shifts)
//   out_valid_o / out_ready_i result handshake; result held until taken
//   aluout_o                  {hi,lo}; hi=0 for single-cycle ops
//   zero_o                    low half of aluout_o is zero
//   busy_o                    multiply/divide iteration in progress
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [OP_W-1:0]    aluop_i,
    input  logic [WIDTH-1:0]   src0_i,
    input  logic [WIDTH-1:0]   src1_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] aluout_o,
    output logic               zero_o,
    output logic               busy_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    logic               out_valid_q, accept, is_mul, is_div, mdu_start, mdu_signed;
    logic               mdu_last;
    logic [2*WIDTH-1:0] aluout_q, mdu_result;
    logic [WIDTH-1:0]   simple_res;
    logic [SHW-1:0]     shamt;

    always_comb begin
        is_mul     = (aluop_i == OP_W'(ALUOP_MULT)) || (aluop_i == OP_W'(ALUOP_MULTU));
`ifdef ALU_DIV_EN
        is_div     = (aluop_i == OP_W'(ALUOP_DIV)) || (aluop_i == OP_W'(ALUOP_DIVU));
`else
        is_div     = 1'b0;
`endif
        mdu_signed = (aluop_i == OP_W'(ALUOP_MULT)) || (aluop_i == OP_W'(ALUOP_DIV));
    end

    always_comb begin
        shamt      = src0_i[SHW-1:0];
        simple_res = '0;
        case (aluop_i)
            OP_W'(ALUOP_AND):  simple_res = src0_i & src1_i;
            OP_W'(ALUOP_OR):   simple_res = src0_i | src1_i;
            OP_W'(ALUOP_NOR):  simple_res = ~(src0_i | src1_i);
            OP_W'(ALUOP_LUI):  simple_res = src1_i << 16;
            OP_W'(ALUOP_ADD):  simple_res = src0_i + src1_i;
            OP_W'(ALUOP_SUB):  simple_res = src0_i - src1_i;
            OP_W'(ALUOP_SLT):  simple_res = {{(WIDTH-1){1'b0}}, $signed(src0_i) < $signed(src1_i)};
            OP_W'(ALUOP_SLTU): simple_res = {{(WIDTH-1){1'b0}}, src0_i < src1_i};
            OP_W'(ALUOP_SLL):  simple_res = src1_i << shamt;
            OP_W'(ALUOP_SRL):  simple_res = src1_i >> shamt;
            OP_W'(ALUOP_SRA):  simple_res = WIDTH'($signed(src1_i) >>> shamt);
            default:           simple_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ready_o   = (state_q == ST_IDLE) && (!out_valid_q || out_ready_i);
        accept    = valid_i && ready_o;
        mdu_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mul) begin
                    state_d   = ST_MUL;
                    mdu_start = 1'b1;
                end else if (accept && is_div) begin
                    state_d   = ST_DIV;
                    mdu_start = 1'b1;
                end
            end
            ST_MUL, ST_DIV: if (mdu_last) state_d = ST_DONE;
            ST_DONE:        state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
        end else if (state_q == ST_DONE) begin
            out_valid_q <= 1'b1;
            aluout_q    <= mdu_result;
        end else if (accept && !is_mul && !is_div) begin
            out_valid_q <= 1'b1;
            aluout_q    <= {{WIDTH{1'b0}}, simple_res};
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    alu_iter_mdu #(.WIDTH(WIDTH)) u_mdu (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (mdu_start),
        .div_i    (is_div),
        .signed_i (mdu_signed),
        .a_i      (src0_i),
        .b_i      (src1_i),
        .busy_o   (busy_o),
        .last_o   (mdu_last),
        .result_o (mdu_result)
    );

    assign out_valid_o = out_valid_q;
    assign aluout_o    = aluout_q;
    assign zero_o      = (aluout_q[WIDTH-1:0] == '0);

endmodule

// File: tb/tb_alu_iter.sv
`timescale 1ns/1ps
module tb_alu_iter;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, valid = 1'b0, out_ready = 1'b0;
    logic        ready, out_valid, zero, busy;
    logic [4:0]  aluop = '0;
    logic [31:0] src0 = '0, src1 = '0;
    logic [63:0] aluout;

    alu_iter #(.WIDTH(32), .OP_W(5)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid), .ready_o(ready),
        .aluop_i(aluop), .src0_i(src0), .src1_i(src1),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .aluout_o(aluout), .zero_o(zero), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, cyc = 0, bp_mode = 0;
    bit   fresh = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: random backpressure, 2: hold off
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] r, output int lat);
        logic [31:0] t;
        longint      sp;
        int          qi, ri;
        r = '0; lat = 1; t = '0;
        case (int'(op))
            ALUOP_AND:   t = a & b;
            ALUOP_OR:    t = a | b;
            ALUOP_NOR:   t = ~(a | b);
            ALUOP_LUI:   t = {b[15:0], 16'h0};
            ALUOP_ADD:   t = a + b;
            ALUOP_SUB:   t = a - b;
            ALUOP_SLT:   t = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALUOP_SLTU:  t = (a < b) ? 32'd1 : 32'd0;
            ALUOP_SLL:   t = b << a[4:0];
            ALUOP_SRL:   t = b >> a[4:0];
            ALUOP_SRA:   t = $signed(b) >>> a[4:0];
            ALUOP_MULT:  begin lat = 33; sp = longint'($signed(a)) * longint'($signed(b)); r = sp; end
            ALUOP_MULTU: begin lat = 33; r = {32'h0, a} * {32'h0, b}; end
`ifdef ALU_DIV_EN
            ALUOP_DIV: begin
                lat = 33;
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else begin
                    qi = $signed(a) / $signed(b);
                    ri = $signed(a) % $signed(b);
                    r  = {ri, qi};
                end
            end
            ALUOP_DIVU: begin
                lat = 33;
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else        r = {a % b, a / b};
            end
`endif
            default: t = '0;
        endcase
        if (lat == 1) r = {32'h0, t};
    endfunction

    // Drive a request; returns once the next rising edge will accept it.
    task automatic issue_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] e, input int lat, output int waits);
        exp_t x;
        @(posedge clk); #1;
        valid = 1'b1; aluop = op; src0 = a; src1 = b; waits = 0;
        forever begin
            @(negedge clk);
            if (ready) break;
            waits++;
            if (waits > 300) begin
                total++; bad++;
                $display("FAIL accept_timeout op=%0d waited=%0d want<=300", op, waits);
                return;
            end
        end
        x.res = e; x.acc = cyc; x.lat = lat;
        q.push_back(x);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int lat, w;
        model(op, a, b, e, lat);
        issue_exp(op, a, b, e, lat, w);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain pending=%0d want=0", nm, q.size());
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: every visible result must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_out got=%h want=none", aluout);
            end else begin
                if (fresh) begin
                    fresh = 1'b0;
                    chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                end
                chk("aluout", aluout, q[0].res);
                if (out_ready) begin
                    chk("zero", {63'h0, zero}, {63'h0, q[0].res[31:0] == 32'h0});
                    void'(q.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int w;
        logic [4:0] op;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_aluout", aluout, 64'h0);
        chk("rst_zero", {63'h0, zero}, 64'h1);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_ready", {63'h0, ready}, 64'h1);
        @(posedge clk); #1 rst_n = 1'b1;

        bp_mode = 0;
        issue_exp(5'(ALUOP_ADD),  32'h7FFFFFFF, 32'h1,        64'h0000_0000_8000_0000, 1, w);
        issue_exp(5'(ALUOP_SUB),  32'd5,        32'd5,        64'h0,                   1, w);
        issue_exp(5'(ALUOP_SRA),  32'd4,        32'h80000000, 64'h0000_0000_F800_0000, 1, w);
        issue_exp(5'(ALUOP_SLT),  32'hFFFFFFFF, 32'h1,        64'h1,                   1, w);
        issue_exp(5'(ALUOP_SLTU), 32'hFFFFFFFF, 32'h1,        64'h0,                   1, w);
        issue_exp(5'(ALUOP_LUI),  32'h0,        32'h1234ABCD, 64'h0000_0000_ABCD_0000, 1, w);
        issue_exp(5'(ALUOP_NOR),  32'h0,        32'h0,        64'h0000_0000_FFFF_FFFF, 1, w);
        issue_exp(5'(ALUOP_SLL),  32'd35,       32'h1,        64'h8,                   1, w);
        issue_exp(5'd15,          32'h1234,     32'h5678,     64'h0,                   1, w);
        issue_exp(5'(ALUOP_MULT),  32'hFFFFFFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, w);
        issue_exp(5'(ALUOP_MULTU), 32'hFFFFFFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 33, w);
`ifdef ALU_DIV_EN
        issue_exp(5'(ALUOP_DIV),  32'hFFFFFFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 33, w);
        issue_exp(5'(ALUOP_DIVU), 32'd7,        32'd0,        64'h0000_0007_FFFF_FFFF, 33, w);
        issue_exp(5'(ALUOP_DIV),  32'h80000000, 32'hFFFFFFFF, 64'h0000_0000_8000_0000, 33, w);
`else
        issue_exp(5'(ALUOP_DIV),  32'd7,        32'd2,        64'h0,                   1, w);
`endif
        idle();
        drain("directed");

        // Backpressure, then drain and accept on the same edge.
        bp_mode = 2;
        issue_exp(5'(ALUOP_ADD), 32'd3, 32'd4, 64'd7, 1, w);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready_low", {63'h0, ready}, 64'h0);
            chk("bp_valid_held", {63'h0, out_valid}, 64'h1);
        end
        bp_mode = 0;
        issue_exp(5'(ALUOP_SUB), 32'd9, 32'd4, 64'd5, 1, w);
        chk("drain_accept_waits", 64'(w), 64'h0);
        idle();
        drain("backpressure");

        // Reset during a multiply iteration: nothing may come out afterwards.
        issue_exp(5'(ALUOP_MULT), 32'd5, 32'd7, 64'd35, 33, w);
        idle();
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_mult", {63'h0, busy}, 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        fresh = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("postrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("postrst_ready", {63'h0, ready}, 64'h1);

        // Randomised traffic with random backpressure.
        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
            issue(op, rand_operand(), rand_operand());
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        idle();
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
